fetch_pc_stage: RTL and testbench
=================================

// Module: fetch_pc_stage
// PURPOSE
//  PC register plus instruction-fetch stage with IF/ID pipeline register.
//  Supplies pc_plus4_o to the next-PC selector and loads that selector's result (next_pc_i) on each completed fetch.
//  Talks to instruction memory through a req/ready handshake, and honours stall_i from the hazard unit and flush_i from exception/ERET logic.
//  Feeds the ID stage with {pc, pc+4, instr, valid}.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction driven on ifid_instr_o whenever no valid instruction is held
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst_n         in   1   synchronous reset, active low
//  next_pc_i     in   32  next PC from the PC source selector (jump, branch, jr or pc+4)
//  stall_i       in   1   hold the PC and the IF/ID register (load-use or multi-cycle stall)
//  flush_i       in   1   discard in-flight work and redirect to flush_pc_i
//  flush_pc_i    in   32  redirect target (exception vector or EPC)
//  imem_ready_i  in   1   imem completes the request this cycle
//  imem_rdata_i  in   32  instruction word; valid when imem_req_o && imem_ready_i
//  imem_req_o    out  1   fetch request
//  imem_addr_o   out  32  fetch address; always equals pc_o
//  pc_o          out  32  current PC
//  pc_plus4_o    out  32  pc_o + 4, combinational, mod 2^32; goes to the selector's ADD4 input
//  ifid_pc_o     out  32  PC of the instruction in IF/ID
//  ifid_pc4_o    out  32  ifid_pc_o + 4, registered
//  ifid_instr_o  out  32  instruction in IF/ID
//  ifid_valid_o  out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (rst_n==0 at posedge):
//   - state=BOOT, pc=RESET_PC, ifid_pc=0, ifid_pc4=0, ifid_instr=NOP_INSTR, ifid_valid=0
//   - skid buffer=0, redirect reg=0, imem_req_o=0
//   - reset wins over every other input in that cycle.
//  Handshake:
//   - A transfer completes on a cycle with imem_req_o && imem_ready_i.
//   - Once raised, req and addr hold stable until that cycle. A request is never withdrawn, including on flush.
//  PC loads (next_pc_i / flush_pc_i): bits [1:0] are forced to 2'b00.
//  Branch delay slot: no squash on a taken branch; the selector already resolves in ID.
//  Priority: flush_i > stall_i > normal.
//  "Load IF/ID" means ifid <= {pc, pc+4, rdata-or-buffer, valid=1}.
//  "Bubble" means ifid_valid <= 0 and ifid_instr <= NOP_INSTR; ifid_pc and ifid_pc4 keep their values.
//  States:
//   - BOOT (req=0): one cycle, then go to FETCH.
//   - FETCH (req=1):
//      ready&&flush : discard data; pc<=flush_pc_i; bubble; stay in FETCH.
//      ready&&stall : buf<=imem_rdata_i; go to HOLD; pc and IF/ID unchanged.
//      ready        : load IF/ID from imem_rdata_i; pc<=next_pc_i; stay in FETCH. Zero-wait memory gives 1 instr/cycle.
//      !ready&&flush: redir<=flush_pc_i; bubble; go to DRAIN.
//      !ready&&stall: hold everything.
//      !ready       : bubble; stay in FETCH.
//   - HOLD (req=0):
//      flush : drop buf; pc<=flush_pc_i; bubble; go to FETCH.
//      stall : hold.
//      else  : load IF/ID from buf; pc<=next_pc_i; go to FETCH.
//   - DRAIN (req=1, addr = old pc): finish the abandoned request; IF/ID stays invalid; stall_i ignored.
//      ready : discard data; pc <= (flush_i ? flush_pc_i : redir); go to FETCH.
//      flush without ready: redir<=flush_pc_i (latest flush wins).
//  Other rules:
//   - next_pc_i is sampled only in the cycle the PC loads. ID content is frozen until then, so a branch in ID stays consistent across wait states.
//   - Arithmetic wraps: pc 32'hFFFF_FFFC gives pc_plus4_o = 0.
//   - Reset mid-transaction: req drops immediately. imem must tolerate abandonment only on reset.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles, then 1.
//     -> pc_o=0x3000, req=0, ifid_valid=0, ifid_instr=NOP_INSTR.
//     -> req=0 in the first cycle after release; req=1, addr=0x3000 in the next.
//  2. Streaming: ready=1, next_pc_i=pc_plus4_o, no stall or flush.
//     -> addr 0x3000, 0x3004, 0x3008 on consecutive cycles.
//     -> ifid_pc lags addr by one cycle; ifid_pc4=ifid_pc+4; ifid_valid=1.
//  3. Stall on completion: ready=1, stall_i=1 at addr 0x3004, rdata=0x8C010000.
//     -> req=0 next cycle; IF/ID unchanged while stalled.
//     -> after stall drops: ifid_instr=0x8C010000, ifid_pc=0x3004, pc=next_pc_i.
//  4. Wait states: ready=0 for 3 cycles at addr 0x3008.
//     -> addr stable for 3 cycles; ifid_valid=0 and ifid_instr=NOP_INSTR during the bubbles.
//     -> valid=1 the cycle after ready.
//  5. Flush in flight: flush_i with flush_pc_i=0x4180 while ready=0 at 0x300C, then ready=1 two cycles later.
//     -> addr stays 0x300C until ready; data discarded; ifid_valid=0; next addr=0x4180.
//  6. Corner cases:
//     flush+stall in HOLD -> pc=flush_pc_i, ifid_valid=0.
//     pc=0xFFFF_FFFC -> pc_plus4_o=0.
//     next_pc_i=0x0000_3006 -> pc=0x0000_3004.

Source files
------------

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage
//   Holds the program counter and the IF/ID pipeline register. It fetches from
//   instruction memory over a req/ready handshake. It honours stall_i from the
//   hazard unit and flush_i from exception/ERET logic.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   next_pc_i         PC chosen by the next-PC selector; loaded on a completed fetch
//   stall_i           hold PC and IF/ID
//   flush_i           redirect to flush_pc_i and drop in-flight work
//   flush_pc_i        redirect target
//   imem_ready_i      memory completes the outstanding request this cycle
//   imem_rdata_i      fetched word, valid with imem_req_o && imem_ready_i
//   imem_req_o        fetch request
//   imem_addr_o       fetch address (always pc_o)
//   pc_o, pc_plus4_o  current PC and PC+4 (combinational, wraps)
//   ifid_*            IF/ID register contents handed to decode
module fetch_pc_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_pc4_o,
   output logic [31:0] ifid_instr_o,
   output logic        ifid_valid_o
);

   // BOOT : one idle cycle after reset
   // FETCH: request outstanding at pc_q
   // HOLD : word captured into buf_q while stalled; no request
   // DRAIN: finishing a request that a flush has abandoned
   typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HOLD, ST_DRAIN} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] redir_q, redir_d;

   logic        xfer;
   logic [31:0] next_pc_al;
   logic [31:0] flush_pc_al;

   // PC targets are always word aligned.
   assign next_pc_al  = next_pc_i  & ~32'h3;
   assign flush_pc_al = flush_pc_i & ~32'h3;
   assign xfer        = imem_req_o && imem_ready_i;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_BOOT;
      else        state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_BOOT:  state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ready_i) begin
               if (flush_i)      state_d = ST_FETCH;
               else if (stall_i) state_d = ST_HOLD;
               else              state_d = ST_FETCH;
            end else if (flush_i) begin
               // The request cannot be withdrawn, so it is finished in DRAIN.
               state_d = ST_DRAIN;
            end
         end
         ST_HOLD: begin
            if (flush_i)       state_d = ST_FETCH;
            else if (!stall_i) state_d = ST_FETCH;
         end
         ST_DRAIN: begin
            if (imem_ready_i) state_d = ST_FETCH;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      imem_req_o = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      buf_d        = buf_q;
      redir_d      = redir_q;

      unique case (state_q)
         ST_FETCH: begin
            if (flush_i) begin
               // A completing word is discarded. Otherwise the target is
               // remembered until the abandoned request finishes.
               if (xfer) pc_d = flush_pc_al;
               else      redir_d = flush_pc_al;
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
            end else if (stall_i) begin
               if (xfer) buf_d = imem_rdata_i;
            end else if (xfer) begin
               ifid_pc_d    = pc_q;
               ifid_pc4_d   = pc_q + 32'd4;
               ifid_instr_d = imem_rdata_i;
               ifid_valid_d = 1'b1;
               pc_d         = next_pc_al;
            end else begin
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
            end
         end
         ST_HOLD: begin
            if (flush_i) begin
               pc_d         = flush_pc_al;
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
            end else if (!stall_i) begin
               ifid_pc_d    = pc_q;
               ifid_pc4_d   = pc_q + 32'd4;
               ifid_instr_d = buf_q;
               ifid_valid_d = 1'b1;
               pc_d         = next_pc_al;
            end
         end
         ST_DRAIN: begin
            // IF/ID is already a bubble; stall_i plays no part here.
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            if (imem_ready_i)  pc_d    = flush_i ? flush_pc_al : redir_q;
            else if (flush_i)  redir_d = flush_pc_al;
         end
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         ifid_pc_q    <= 32'd0;
         ifid_pc4_q   <= 32'd0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
         buf_q        <= 32'd0;
         redir_q      <= 32'd0;
      end else begin
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         buf_q        <= buf_d;
         redir_q      <= redir_d;
      end
   end

   assign pc_o         = pc_q;
   assign pc_plus4_o   = pc_q + 32'd4;
   assign imem_addr_o  = pc_q;
   assign ifid_pc_o    = ifid_pc_q;
   assign ifid_pc4_o   = ifid_pc4_q;
   assign ifid_instr_o = ifid_instr_q;
   assign ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
module tb_fetch_pc_stage;
   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] next_pc_i = 32'd0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] flush_pc_i = 32'd0;
   logic        imem_ready_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'd0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o, pc_o, pc_plus4_o;
   logic [31:0] ifid_pc_o, ifid_pc4_o, ifid_instr_o;
   logic        ifid_valid_o;

   fetch_pc_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk(clk), .rst_n(rst_n), .next_pc_i(next_pc_i), .stall_i(stall_i),
      .flush_i(flush_i), .flush_pc_i(flush_pc_i), .imem_ready_i(imem_ready_i),
      .imem_rdata_i(imem_rdata_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .ifid_pc_o(ifid_pc_o),
      .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o), .ifid_valid_o(ifid_valid_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: transaction-level view of the fetch unit.
   //   exp_pc    address the unit must present / hold
   //   booting   first cycle out of reset, no request yet
   //   buffered  a fetched word is parked while decode is stalled
   //   doomed    the outstanding request was abandoned by a flush
   // Every instruction that must reach decode is pushed into exp_q.
   typedef struct { logic [31:0] pc; logic [31:0] pc4; logic [31:0] instr; } item_t;
   item_t       exp_q[$];
   bit          known = 0;
   bit          booting, buffered, doomed;
   logic [31:0] exp_pc, parked, redirect;

   function automatic logic [31:0] al(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

   always @(negedge clk) begin
      if (known) begin
         chk("req", {31'd0, imem_req_o}, {31'd0, !booting && !buffered});
         chk("pc", pc_o, exp_pc);
         chk("pc_plus4", pc_plus4_o, exp_pc + 32'd4);
         chk("addr", imem_addr_o, exp_pc);
      end
      if (!rst_n) begin
         exp_q.delete();
         booting = 1; buffered = 0; doomed = 0;
         exp_pc = RESET_PC; parked = 0; redirect = 0;
         known = 1;
      end else if (known) begin
         if (booting) begin
            booting = 0;
         end else if (buffered) begin
            if (flush_i) begin
               buffered = 0; exp_pc = al(flush_pc_i);
            end else if (!stall_i) begin
               exp_q.push_back('{exp_pc, exp_pc + 32'd4, parked});
               buffered = 0; exp_pc = al(next_pc_i);
            end
         end else if (doomed) begin
            if (imem_ready_i) begin
               doomed = 0; exp_pc = flush_i ? al(flush_pc_i) : redirect;
            end else if (flush_i) begin
               redirect = al(flush_pc_i);
            end
         end else if (imem_ready_i) begin
            if (flush_i) exp_pc = al(flush_pc_i);
            else if (stall_i) begin
               parked = imem_rdata_i; buffered = 1;
            end else begin
               exp_q.push_back('{exp_pc, exp_pc + 32'd4, imem_rdata_i});
               exp_pc = al(next_pc_i);
            end
         end else if (flush_i) begin
            doomed = 1; redirect = al(flush_pc_i);
         end
      end
   end

   // Monitor: decode consumes the IF/ID content on any cycle it is not held.
   always @(negedge clk) begin
      if (known && rst_n) begin
         if (ifid_valid_o !== 1'b1) begin
            chk("ifid_nop", ifid_instr_o, NOP_INSTR);
         end else if (!stall_i || flush_i) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL ifid_unexpected: got valid pc %h, expected no instruction", ifid_pc_o);
            end else begin
               item_t e;
               e = exp_q.pop_front();
               chk("ifid_pc", ifid_pc_o, e.pc);
               chk("ifid_pc4", ifid_pc4_o, e.pc4);
               chk("ifid_instr", ifid_instr_o, e.instr);
            end
         end
      end
   end

   bit follow = 1;

   task automatic tick();
      @(posedge clk);
      #1;
      imem_rdata_i = $urandom;
      if (follow) next_pc_i = pc_plus4_o;
   endtask

   initial begin
      // reset, then streaming
      repeat (2) tick();
      rst_n = 1;
      imem_ready_i = 1;
      repeat (4) tick();
      // stall on completion
      stall_i = 1; repeat (2) tick();
      stall_i = 0; repeat (2) tick();
      // wait states
      imem_ready_i = 0; repeat (3) tick();
      imem_ready_i = 1; tick();
      // flush while request outstanding
      imem_ready_i = 0; tick();
      flush_i = 1; flush_pc_i = 32'h0000_4180; tick();
      flush_i = 0; tick();
      imem_ready_i = 1; repeat (2) tick();
      // flush + stall while holding a parked word
      stall_i = 1; tick();
      flush_i = 1; flush_pc_i = 32'h0000_5002; tick();
      flush_i = 0; stall_i = 0; repeat (2) tick();
      // misaligned target and PC wrap
      follow = 0;
      next_pc_i = 32'h0000_3006; tick();
      next_pc_i = 32'hFFFF_FFFC; tick();
      follow = 1; repeat (3) tick();
      // randomized traffic with one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         rst_n        = (i != 1500);
         imem_ready_i = ($urandom % 4) != 0;
         stall_i      = ($urandom % 5) == 0;
         flush_i      = ($urandom % 12) == 0;
         flush_pc_i   = $urandom;
         follow       = ($urandom % 2) != 0;
         if (!follow) next_pc_i = $urandom;
         tick();
      end
      rst_n = 1; follow = 1;
      imem_ready_i = 0; stall_i = 0; flush_i = 0;
      repeat (4) tick();
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
